// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter : two-port burst arbiter in front of a banked memory, with read-return tagging
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arbiter #(
    parameter int RD_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic        rd0,
    input  logic        wr0,
    input  logic        rd1,
    input  logic        wr1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_DataOut,
    input  logic        mem_stall,
    output logic        gnt0,
    output logic        gnt1,
    output logic        stall0,
    output logic        stall1,
    output logic [15:0] rdata,
    output logic        rvalid0,
    output logic        rvalid1,
    output logic        arb_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        OWN0  = 3'd1,
        OWN1  = 3'd2,
        DRAIN = 3'd3
    } state_t;

    state_t            state_q, state_d;
    logic              last_owner_q, last_owner_d;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [RD_LAT-1:0] id_q, id_d;
    logic              accept;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            vld_q        <= '0;
            id_q         <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            vld_q        <= vld_d;
            id_q         <= id_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_data_in  = '0;
        arb_err      = 1'b0;
        stall0       = req0;
        stall1       = req1;
        case (state_q)
            IDLE: begin
                // On a tie, last_owner_q==1 hands the grant to port 0.
                if (req0 && (!req1 || last_owner_q)) begin
                    state_d      = OWN0;
                    last_owner_d = 1'b0;
                end else if (req1) begin
                    state_d      = OWN1;
                    last_owner_d = 1'b1;
                end
            end
            OWN0: begin
                gnt0    = 1'b1;
                stall0  = mem_stall;
                arb_err = rd0 & wr0;
                if (req0) begin
                    if (!(rd0 && wr0)) begin
                        mem_rd = rd0;
                        mem_wr = wr0;
                    end
                    mem_addr    = addr0;
                    mem_data_in = wdata0;
                end else begin
                    state_d = DRAIN;
                end
            end
            OWN1: begin
                gnt1    = 1'b1;
                stall1  = mem_stall;
                arb_err = rd1 & wr1;
                if (req1) begin
                    if (!(rd1 && wr1)) begin
                        mem_rd = rd1;
                        mem_wr = wr1;
                    end
                    mem_addr    = addr1;
                    mem_data_in = wdata1;
                end else begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Hold off re-arbitration until every in-flight read has returned.
                if (vld_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                arb_err = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    assign accept = mem_rd & ~mem_stall;

    always_comb begin
        vld_d    = '0;
        id_d     = '0;
        vld_d[0] = accept;
        id_d[0]  = (state_q == OWN1);
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
        end
    end

    assign rvalid0 = vld_q[RD_LAT-1] & ~id_q[RD_LAT-1];
    assign rvalid1 = vld_q[RD_LAT-1] &  id_q[RD_LAT-1];
    assign rdata   = mem_DataOut;

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: req0/req1  in  1 each  requester holds high for the whole burst (fill or writeback).
REQ-004 SHALL have ports: rd0/wr0, rd1/wr1  in  1 each  per-cycle memory read/write strobes.
REQ-005 SHALL have ports: addr0/addr1  in  16 each; wdata0/wdata1  in  16 each.
REQ-006 SHALL have ports: mem_rd, mem_wr  out  1 each; mem_addr  out  16; mem_data_in  out  16.
REQ-007 SHALL have ports: mem_DataOut  in  16  read data from the banked memory; mem_stall  in  1  addressed bank busy.
REQ-008 SHALL have ports: gnt0/gnt1  out  1 each; stall0/stall1  out  1 each; rdata  out  16; rvalid0/rvalid1  out  1 each; arb_err  out  1.
REQ-009 SHALL have parameter RD_LAT, default 2: cycles from accepted read to data on mem_DataOut.

Function
REQ-010 SHALL implement states IDLE, OWN0, OWN1, DRAIN, held in a registered state vector.
REQ-011 IDLE: only req0 -> OWN0; only req1 -> OWN1; both -> the port not equal to last_owner; neither -> IDLE.
REQ-012 last_owner SHALL update to x on entry to OWNx.
REQ-013 gntx SHALL be 1 exactly while state == OWNx, so the grant is registered: it appears the cycle after req is first seen in IDLE.
REQ-014 In OWNx, mem_rd/mem_wr/mem_addr/mem_data_in SHALL combinationally equal rdx/wrx/addrx/wdatax.
REQ-015 In every state other than OWNx, mem_rd and mem_wr SHALL be 0, and mem_addr and mem_data_in SHALL be 0.
REQ-016 stallx SHALL equal mem_stall in OWNx, and SHALL be 1 whenever reqx=1 and state != OWNx; otherwise it SHALL be 0.
REQ-017 A read SHALL be accepted when mem_rd=1 and mem_stall=0.
REQ-018 Each cycle, an RD_LAT-deep shift pipeline SHALL record {valid=accepted, id=owner}.
REQ-019 rvalidx SHALL be 1 when the pipeline tail is valid with id == x; rdata SHALL equal mem_DataOut every cycle.
REQ-020 OWNx with reqx=0 SHALL go to DRAIN; in that cycle the outputs SHALL be the forced-idle values of REQ-015.
REQ-021 DRAIN SHALL remain until the read pipeline holds no valid entry, then go to IDLE; arbitration restarts from IDLE, with no direct OWN0 -> OWN1 transition.
REQ-022 Reads accepted before a grant change SHALL still deliver rvalid to their original owner.
REQ-023 arb_err SHALL be 1 in OWNx when rdx & wrx; in that case the arbiter SHALL still drive mem_rd = mem_wr = 0.
REQ-024 arb_err SHALL be 1 for an illegal state encoding, which SHALL go to IDLE next cycle.
REQ-025 Strobes on a non-granted port SHALL be ignored and never reach memory.
REQ-026 Dropping req while mem_stall=1 SHALL still go to DRAIN, and the stalled access SHALL be abandoned.
REQ-027 A requester re-asserting req during DRAIN SHALL be considered in IDLE under the REQ-011 rules.

Reset
REQ-028 rst=0 SHALL asynchronously force state=IDLE, last_owner=1 (port 0 wins the first tie), and all pipeline valid bits=0.
REQ-029 During reset, gnt0/gnt1, rvalid0/rvalid1, mem_rd, mem_wr and arb_err SHALL be 0.
REQ-030 During reset, stall0/stall1 SHALL equal req0/req1, and mem_addr and mem_data_in SHALL be 0.
REQ-031 Reset asserted mid-burst SHALL discard in-flight reads, with no rvalid after release; the first grant after release SHALL come from IDLE.

Verification
REQ-032 Single owner: req0=1 at T -> gnt0=1 at T+1; rd0 with addr0=0x1230 at T+1 -> mem_addr=0x1230 at T+1; rvalid0=1 at T+3, rdata=mem_DataOut.
REQ-033 Tie fairness: req0 and req1 both held continuously from reset, each dropped after 4 cycles of grant -> grants alternate 0, 1, 0, and the loser sees stall=1 throughout.
REQ-034 Drain: req0 drops one cycle after a read is accepted -> DRAIN is held until rvalid0 pulses, gnt1 is not asserted earlier, and rvalid1 stays 0.
REQ-035 Backpressure: mem_stall=1 for 3 cycles in OWN1 with rd1=1 -> stall1=1 for those 3 cycles, one read is accepted afterwards, and exactly one rvalid1 pulse occurs.
REQ-036 Error: rd0=wr0=1 while granted -> arb_err=1 and mem_rd=mem_wr=0 that cycle.
REQ-037 Async reset: rst low mid-OWN1 with a read in flight -> gnt1=0 immediately, no rvalid1 afterwards, and with both req asserted after release port 0 is granted first.
